pe_dotp_sequencer: RTL

- Command-driven controller that sequences the 4-lane PE array through one dot product.
- Accepts a command giving a vector length in 4-element chunks, two operand base addresses and a result address.
- Drives operand-memory read addresses and a latency-aligned opcode stream: one DOTP per chunk, a NOOP drain, then STORE_RESULT.
- Sits between the instruction/command front end and the PE array plus operand memories; reports done when the accumulator result has been stored.

---
 rtl/pe_dotp_sequencer.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pe_dotp_sequencer.sv
// ---------------------------------------------------------------------------
// pe_dotp_sequencer
//
// Walks the 4-lane PE array through one dot product per command. A command
// gives a length in 4-element chunks, two operand base addresses and a
// result address. The block issues one operand read and one DOTP per chunk
// with no bubbles. It then inserts a NOOP drain, issues a single
// STORE_RESULT, and waits for the PE array to commit the store. After that
// it pulses done.
//
// Optional feature (compile-time macro PE_DOTP_SEQ_PERF_EN):
//   perf_cmds        - count of completed commands
//   perf_busy_cycles - count of cycles with busy high
//
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (ready only while idle)
//   cmd_len              chunk count (0 is legal: store only)
//   cmd_addr_a/b/r       operand A/B base and result address
//   rd_en, rd_addr_a/b   operand-memory read strobe and addresses
//   pe_opcode            opcode stream, delayed to line up with read data
//   res_addr             latched result address
//   busy, done           activity flag and one-cycle completion pulse
// ---------------------------------------------------------------------------
module pe_dotp_sequencer #(
    parameter int ADDR_WIDTH    = 10,
    parameter int LEN_WIDTH     = 8,
    parameter int OPCODE_WIDTH  = 3,
    parameter int RD_LATENCY    = 1,
    parameter int DRAIN_CYCLES  = 2,
    parameter int STORE_LATENCY = 3
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_a,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_b,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_r,
    output logic                    rd_en,
    output logic [ADDR_WIDTH-1:0]   rd_addr_a,
    output logic [ADDR_WIDTH-1:0]   rd_addr_b,
    output logic [OPCODE_WIDTH-1:0] pe_opcode,
    output logic [ADDR_WIDTH-1:0]   res_addr,
    output logic                    busy,
    output logic                    done
`ifdef PE_DOTP_SEQ_PERF_EN
    ,
    output logic [31:0]             perf_cmds,
    output logic [31:0]             perf_busy_cycles
`endif
);

    localparam logic [OPCODE_WIDTH-1:0] OP_NOOP  = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_DOTP  = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(7);

    // WAIT covers the opcode delay line plus the PE array's store latency.
    localparam int WAIT_CYCLES = RD_LATENCY + STORE_LATENCY;
    localparam int PH_W        = 16;

    localparam logic [LEN_WIDTH:0] CHUNK_ONE = (LEN_WIDTH + 1)'(1);
    localparam logic [PH_W-1:0]    PH_ONE    = PH_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_STORE,
        S_WAIT
    } state_t;

    state_t                  state_reg,  state_next;
    // One bit wider than cmd_len so that a length of all ones cannot overflow.
    logic [LEN_WIDTH:0]      chunk_reg,  chunk_next;
    logic [LEN_WIDTH-1:0]    len_reg,    len_next;
    logic [ADDR_WIDTH-1:0]   addr_a_reg, addr_a_next;
    logic [ADDR_WIDTH-1:0]   addr_b_reg, addr_b_next;
    logic [ADDR_WIDTH-1:0]   addr_r_reg, addr_r_next;
    logic [PH_W-1:0]         phase_reg,  phase_next;
    logic                    done_reg,   done_next;
    logic [OPCODE_WIDTH-1:0] raw_opcode;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg  <= S_IDLE;
            chunk_reg  <= '0;
            len_reg    <= '0;
            addr_a_reg <= '0;
            addr_b_reg <= '0;
            addr_r_reg <= '0;
            phase_reg  <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            chunk_reg  <= chunk_next;
            len_reg    <= len_next;
            addr_a_reg <= addr_a_next;
            addr_b_reg <= addr_b_next;
            addr_r_reg <= addr_r_next;
            phase_reg  <= phase_next;
            done_reg   <= done_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and raw (undelayed) opcode
    // -----------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        chunk_next  = chunk_reg;
        len_next    = len_reg;
        addr_a_next = addr_a_reg;
        addr_b_next = addr_b_reg;
        addr_r_next = addr_r_reg;
        phase_next  = phase_reg;
        done_next   = 1'b0;
        raw_opcode  = OP_NOOP;
        rd_en       = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    len_next    = cmd_len;
                    addr_a_next = cmd_addr_a;
                    addr_b_next = cmd_addr_b;
                    addr_r_next = cmd_addr_r;
                    chunk_next  = '0;
                    phase_next  = '0;
                    // A zero-length command still stores the accumulator once.
                    state_next  = (cmd_len != '0) ? S_ISSUE : S_STORE;
                end
            end

            S_ISSUE: begin
                rd_en      = 1'b1;
                raw_opcode = OP_DOTP;
                chunk_next = chunk_reg + CHUNK_ONE;
                if ((chunk_reg + CHUNK_ONE) == {1'b0, len_reg}) begin
                    phase_next = '0;
                    state_next = (DRAIN_CYCLES > 0) ? S_DRAIN : S_STORE;
                end
            end

            S_DRAIN: begin
                phase_next = phase_reg + PH_ONE;
                if (phase_reg == PH_W'(DRAIN_CYCLES - 1)) begin
                    phase_next = '0;
                    state_next = S_STORE;
                end
            end

            S_STORE: begin
                raw_opcode = OP_STORE;
                phase_next = '0;
                if (WAIT_CYCLES > 0) begin
                    state_next = S_WAIT;
                end else begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end

            S_WAIT: begin
                phase_next = phase_reg + PH_ONE;
                if (phase_reg == PH_W'(WAIT_CYCLES - 1)) begin
                    phase_next = '0;
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // done is registered, so it appears in the first IDLE cycle. Holding
    // ready low for that cycle means the next accept lands one cycle later.
    assign cmd_ready = (state_reg == S_IDLE) && !done_reg;
    assign busy      = (state_reg != S_IDLE);
    assign done      = done_reg;
    assign res_addr  = addr_r_reg;

    // Chunk-granular addresses wrap modulo 2^ADDR_WIDTH.
    assign rd_addr_a = addr_a_reg + ADDR_WIDTH'(chunk_reg);
    assign rd_addr_b = addr_b_reg + ADDR_WIDTH'(chunk_reg);

    // -----------------------------------------------------------------------
    // Opcode delay line: lines each opcode up with its operand read data
    // -----------------------------------------------------------------------
    generate
        if (RD_LATENCY == 0) begin : g_no_delay
            assign pe_opcode = raw_opcode;
        end else begin : g_delay
            logic [RD_LATENCY-1:0][OPCODE_WIDTH-1:0] pipe_reg;

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    pipe_reg <= {RD_LATENCY{OP_NOOP}};
                end else begin
                    pipe_reg[0] <= raw_opcode;
                    for (int k = 1; k < RD_LATENCY; k++) begin
                        pipe_reg[k] <= pipe_reg[k-1];
                    end
                end
            end

            assign pe_opcode = pipe_reg[RD_LATENCY-1];
        end
    endgenerate

`ifdef PE_DOTP_SEQ_PERF_EN
    // -----------------------------------------------------------------------
    // Performance counters (free-running, wrap at 2^32)
    // -----------------------------------------------------------------------
    logic [31:0] perf_cmds_reg;
    logic [31:0] perf_busy_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_cmds_reg <= '0;
            perf_busy_reg <= '0;
        end else begin
            // Counted on the same edge that raises done, so the count is
            // already updated while done is visible.
            if (done_next) begin
                perf_cmds_reg <= perf_cmds_reg + 32'd1;
            end
            if (busy) begin
                perf_busy_reg <= perf_busy_reg + 32'd1;
            end
        end
    end

    assign perf_cmds        = perf_cmds_reg;
    assign perf_busy_cycles = perf_busy_reg;
`endif

endmodule
